// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-way round-robin arbiter feeding a one-hot AND-OR data mux and a
// single-entry registered output stage. The output entry carries the one-hot
// source of its data so downstream logic can tag results per channel.
module rr_arb_mux #(
  parameter int N     = 3,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [N-1:0]       out_sel
);

  // ptr is one-hot and marks the channel with the highest priority this cycle
  logic [N-1:0]     ptr;
  logic [N-1:0]     ptr_nxt;
  logic [N-1:0]     grant;
  logic [N-1:0]     req_hi;
  logic [WIDTH-1:0] mux_data;
  logic             load_en;
  logic             xfer;

  // The output stage can take a new entry when it is empty or being drained
  assign load_en = ~out_valid | out_ready;

  // ptr - 1 masks every bit below the pointer, leaving the requests at or above it
  assign req_hi = in_valid & ~(ptr - N'(1));

  // Lowest set bit at or above ptr; if none, wrap and take the lowest set bit overall
  always_comb begin
    if (|req_hi) begin
      grant = req_hi & (~req_hi + N'(1));
    end else begin
      grant = in_valid & (~in_valid + N'(1));
    end
  end

  // grant only ever contains requesting channels, so any ready bit means a transfer
  assign in_ready = grant & {N{load_en & ~reset}};
  assign xfer     = |in_ready;

  // Next pointer sits just past the winner so the winner drops to lowest priority
  if (N == 1) begin : g_rot_single
    assign ptr_nxt = grant;
  end else begin : g_rot_multi
    assign ptr_nxt = {grant[N-2:0], grant[N-1]};
  end

  // AND-OR mux: data of channels without a grant is gated off, so X never leaks through
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < N; j++) begin
      mux_data = mux_data | ({WIDTH{grant[j]}} & in_data[j*WIDTH +: WIDTH]);
    end
  end

  // Output register and pointer: load on transfer, clear valid on drain, hold when stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= N'(1);
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_sel   <= grant;
        ptr       <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=3/W=32, N=4/W=64, N=1/W=32) checked by a
// negedge scoreboard plus directed checks for ordering, stalls, wrap and reset.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [2:0]   v3 = '0, r3;
  logic [95:0]  d3 = '0;
  logic         ov3, or3 = 1'b1;
  logic [31:0]  od3;
  logic [2:0]   os3;

  logic [3:0]   v4 = '0, r4;
  logic [255:0] d4 = '0;
  logic         ov4, or4 = 1'b1;
  logic [63:0]  od4;
  logic [3:0]   os4;

  logic [0:0]   v1 = '0, r1;
  logic [31:0]  d1 = '0;
  logic         ov1, or1 = 1'b1;
  logic [31:0]  od1;
  logic [0:0]   os1;

  int total = 0;
  int bad = 0;

  int          cnt[3][16];
  logic [15:0] acc_m[3];
  int          ptr_m[3];
  bit          act[3];
  logic [15:0] prev_iv[3];
  logic [15:0] prev_acc[3];
  logic [255:0] prev_din[3];
  bit          prev_rst[3];
  logic [79:0] q0[$], q1[$], q2[$];

  // free-running clock
  always #5 clk = ~clk;

  rr_arb_mux #(.N(3), .WIDTH(32)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sel(os3));

  rr_arb_mux #(.N(4), .WIDTH(64)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4));

  rr_arb_mux #(.N(1), .WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sel(os1));

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nof(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 1;
  endfunction

  function automatic int wof(input int k);
    return (k == 1) ? 64 : 32;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'(1) << w) - 64'(1));
  endfunction

  function automatic logic [63:0] slice(input logic [255:0] v, input int i, input int w);
    logic [255:0] t;
    t = v >> (i * w);
    return t[63:0] & wmask(w);
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [79:0] q_pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int k, input logic [79:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void q_clear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // One scoreboard step per instance at the negedge: retire the output entry, then
  // predict this cycle's grant/in_ready and queue the entry it will load.
  task automatic sb_step(input int k, input logic rst, input logic [15:0] iv,
                         input logic [15:0] ir, input logic [255:0] din, input logic ov,
                         input logic orr, input logic [63:0] od, input logic [15:0] os);
    int n, w, sz, idx, gi;
    logic [79:0] e;
    logic [15:0] g, erdy, pend;
    n = nof(k);
    w = wof(k);
    sz = q_size(k);
    gi = 0;
    if (act[k]) begin
      chk("out_valid", 80'(ov), 80'(sz > 0));
      if (ov === 1'b1 && orr === 1'b1 && sz > 0) begin
        e = q_pop(k);
        chk("out_data", 80'(od), 80'(e[63:0]));
        chk("out_sel", 80'(os), 80'(e[79:64]));
        sz--;
      end
      if (!prev_rst[k] && !rst) begin
        pend = prev_iv[k] & ~prev_acc[k];
        if (pend != '0) begin
          chk("prod_valid", 80'(iv & pend), 80'(pend));
          for (int i = 0; i < n; i++)
            if (pend[i]) chk("prod_data", 80'(slice(din, i, w)), 80'(slice(prev_din[k], i, w)));
        end
      end
    end
    prev_iv[k] = iv;
    prev_din[k] = din;
    prev_rst[k] = rst;
    if (rst) begin
      act[k] = 1'b1;
      q_clear(k);
      ptr_m[k] = 0;
      chk("in_ready_rst", 80'(ir), 80'(0));
      acc_m[k] = '0;
      prev_acc[k] = '0;
      return;
    end
    if (!act[k]) begin
      acc_m[k] = '0;
      prev_acc[k] = '0;
      return;
    end
    g = '0;
    for (int o = 0; o < n; o++) begin
      idx = (ptr_m[k] + o) % n;
      if (g == '0 && iv[idx] === 1'b1) begin
        g[idx] = 1'b1;
        gi = idx;
      end
    end
    erdy = (sz == 0) ? g : '0;
    chk("in_ready", 80'(ir), 80'(erdy));
    if (erdy != '0) begin
      q_push(k, {g, slice(din, gi, w)});
      ptr_m[k] = (gi + 1) % n;
    end
    acc_m[k] = iv & erdy;
    prev_acc[k] = acc_m[k];
  endtask

  // scoreboard and producer-rule monitor
  always @(negedge clk) begin
    sb_step(0, reset, 16'(v3), 16'(r3), 256'(d3), ov3, or3, 64'(od3), 16'(os3));
    sb_step(1, reset, 16'(v4), 16'(r4), d4, ov4, or4, od4, 16'(os4));
    sb_step(2, reset, 16'(v1), 16'(r1), 256'(d1), ov1, or1, 64'(od1), 16'(os1));
  end

  task automatic put_data(input int k, input int ch, input logic [63:0] d);
    case (k)
      0: d3[ch*32 +: 32] = d[31:0];
      1: d4[ch*64 +: 64] = d;
      default: d1 = d[31:0];
    endcase
  endtask

  task automatic upd_valid(input int k);
    logic [15:0] m;
    m = '0;
    for (int ch = 0; ch < nof(k); ch++) m[ch] = (cnt[k][ch] > 0);
    case (k)
      0: v3 = m[2:0];
      1: v4 = m[3:0];
      default: v1 = m[0:0];
    endcase
  endtask

  task automatic set_req(input int k, input int ch, input int c, input logic [63:0] d);
    cnt[k][ch] = c;
    put_data(k, ch, d);
    upd_valid(k);
  endtask

  task automatic set_or(input int k, input logic b);
    case (k)
      0: or3 = b;
      1: or4 = b;
      default: or1 = b;
    endcase
  endtask

  function automatic logic get_ov(input int k);
    return (k == 0) ? ov3 : (k == 1) ? ov4 : ov1;
  endfunction

  function automatic logic [15:0] get_os(input int k);
    return (k == 0) ? 16'(os3) : (k == 1) ? 16'(os4) : 16'(os1);
  endfunction

  function automatic logic [63:0] get_od(input int k);
    return (k == 0) ? 64'(od3) : (k == 1) ? od4 : 64'(od1);
  endfunction

  function automatic logic [15:0] get_rdy(input int k);
    return (k == 0) ? 16'(r3) : (k == 1) ? 16'(r4) : 16'(r1);
  endfunction

  // Advance one clock; producers retire accepted items and present the next one
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < nof(k); ch++) begin
        if (acc_m[k][ch] === 1'b1) begin
          cnt[k][ch]--;
          if (cnt[k][ch] > 0) put_data(k, ch, {$urandom, $urandom});
        end
      end
      upd_valid(k);
    end
  endtask

  task automatic drain(input int k);
    bit done;
    bit idle;
    done = 1'b0;
    set_or(k, 1'b1);
    for (int i = 0; i < 60; i++) begin
      idle = (get_ov(k) === 1'b0);
      for (int ch = 0; ch < nof(k); ch++) if (cnt[k][ch] != 0) idle = 1'b0;
      if (idle) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_done", 80'(done), 80'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic contention(input int k);
    int n;
    n = nof(k);
    do_reset();
    for (int ch = 0; ch < n; ch++) set_req(k, ch, 2, {$urandom, $urandom});
    set_or(k, 1'b1);
    #1;
    chk("cont_rdy0", 80'(get_rdy(k)), 80'(1));
    for (int c = 0; c < 2 * n; c++) begin
      tick();
      chk("cont_valid", 80'(get_ov(k)), 80'(1));
      chk("cont_sel", 80'(get_os(k)), 80'(16'(1) << (c % n)));
    end
    drain(k);
  endtask

  task automatic backpressure(input int k);
    int n;
    logic [63:0] dh;
    n = nof(k);
    dh = 64'hA5A5_0F0F_1234_5678;
    set_or(k, 1'b1);
    set_req(k, n - 1, 1, dh);
    tick();
    chk("bp_sel_load", 80'(get_os(k)), 80'(16'(1) << (n - 1)));
    set_or(k, 1'b0);
    for (int ch = 0; ch < n; ch++) set_req(k, ch, 1, {$urandom, $urandom});
    #1;
    chk("bp_rdy_stall", 80'(get_rdy(k)), 80'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 80'(get_ov(k)), 80'(1));
      chk("bp_sel", 80'(get_os(k)), 80'(16'(1) << (n - 1)));
      chk("bp_data", 80'(get_od(k)), 80'(dh & wmask(wof(k))));
      chk("bp_rdy", 80'(get_rdy(k)), 80'(0));
    end
    set_or(k, 1'b1);
    #1;
    chk("bp_rdy_resume", 80'(get_rdy(k)), 80'(1));
    tick();
    chk("bp_sel_next", 80'(get_os(k)), 80'(1));
    drain(k);
  endtask

  // main test sequence
  initial begin
    for (int k = 0; k < 3; k++) begin
      acc_m[k] = '0;
      prev_acc[k] = '0;
      prev_iv[k] = '0;
      prev_din[k] = '0;
      prev_rst[k] = 1'b1;
      act[k] = 1'b0;
      ptr_m[k] = 0;
      for (int ch = 0; ch < 16; ch++) cnt[k][ch] = 0;
    end

    // reset held two cycles with random inputs
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < nof(k); ch++)
        set_req(k, ch, int'($urandom_range(0, 1)), {$urandom, $urandom});
      set_or(k, 1'($urandom_range(0, 1)));
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 80'(get_ov(k)), 80'(0));
      chk("rst_data", 80'(get_od(k)), 80'(0));
      chk("rst_sel", 80'(get_os(k)), 80'(0));
      chk("rst_ready", 80'(get_rdy(k)), 80'(0));
      for (int ch = 0; ch < nof(k); ch++) cnt[k][ch] = 0;
      upd_valid(k);
      set_or(k, 1'b1);
    end
    reset = 1'b0;

    // single channel
    set_req(0, 1, 1, 64'(32'hDEAD_BEEF));
    #1;
    chk("single_rdy", 80'(r3), 80'(3'b010));
    tick();
    chk("single_valid", 80'(ov3), 80'(1));
    chk("single_data", 80'(od3), 80'(32'hDEAD_BEEF));
    chk("single_sel", 80'(os3), 80'(3'b010));
    drain(0);

    contention(0);
    backpressure(0);

    // skip and wrap: make ptr sit at ch1, then request only ch0, then ch0+ch2
    set_req(0, 0, 1, {$urandom, $urandom});
    tick();
    set_req(0, 0, 1, {$urandom, $urandom});
    #1;
    chk("wrap_rdy", 80'(r3), 80'(3'b001));
    tick();
    chk("wrap_sel", 80'(os3), 80'(3'b001));
    set_req(0, 0, 1, {$urandom, $urandom});
    set_req(0, 2, 1, {$urandom, $urandom});
    #1;
    chk("skip_rdy", 80'(r3), 80'(3'b100));
    tick();
    chk("skip_sel", 80'(os3), 80'(3'b100));
    drain(0);

    // reset mid-operation with a held entry and ptr at ch2
    set_or(0, 1'b0);
    set_req(0, 1, 1, {$urandom, $urandom});
    tick();
    chk("mid_held", 80'(ov3), 80'(1));
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 80'(ov3), 80'(0));
    reset = 1'b0;
    set_or(0, 1'b1);
    for (int ch = 0; ch < 3; ch++) set_req(0, ch, 1, {$urandom, $urandom});
    #1;
    chk("mid_rdy", 80'(r3), 80'(3'b001));
    tick();
    chk("mid_sel", 80'(os3), 80'(3'b001));
    drain(0);

    contention(1);
    backpressure(1);
    contention(2);
    backpressure(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
